synth_param_decoder: RTL
========================

Name: synth_param_decoder

Overview:
- Sits directly downstream of the SPI capture controller. It sequences each SPI capture by driving the controller's reset and start inputs, then consumes the 32-bit word and done pulse the controller returns.
- Validates each word, decodes it, and writes a 16-entry x 16-bit synth parameter register file that the synth engine reads.
- Runs continuously on a programmable poll interval, with timeout and error counting.

Parameters:
- POLL_PERIOD, 4096: clk cycles from the end of one transaction to the start of the next.
- RSTN_CYCLES, 2: cycles spi_rstn is held low before start.
- TIMEOUT, 1024: cycles allowed in WAIT_DONE before the transaction is aborted.
- SYNC_NIBBLE, 4'hA: required value of word[31:28].

Ports:
- clk  in  1  system clock, the same divided clock as the SPI controller.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  polling enable; when low, no new transaction starts.
- spi_rstn  out  1  active-low reset to the SPI controller.
- spi_start  out  1  one-cycle start pulse to the SPI controller.
- spi_done  in  1  one-cycle done pulse from the SPI controller.
- spi_data  in  32  captured word, valid in the cycle spi_done is high.
- rd_addr  in  4  parameter read address.
- rd_data  out  16  parameter read data, registered, 1-cycle latency.
- param_we  out  1  one-cycle pulse when a parameter is written.
- param_addr  out  4  address of the last write.
- param_data  out  16  data of the last write.
- err_cnt  out  8  count of rejected words plus timeouts, saturating at 255.
- timeout_flag  out  1  sticky, set on timeout, cleared by reset only.

Behaviour:
- Word format:
  - [31:28] sync nibble.
  - [27:24] address.
  - [23:8] data.
  - [7:0] checksum = word[31:24] ^ word[23:16] ^ word[15:8].
- Reset (rst high, asynchronous): all outputs are reset as follows.
  - spi_rstn=1, spi_start=0, param_we=0, param_addr=0, param_data=0.
  - rd_data=0, err_cnt=0, timeout_flag=0.
  - Register file cleared to 0, FSM to IDLE, poll counter to 0.
- FSM states:
  - IDLE: the poll counter increments while enable=1 and holds at its value while enable=0. When counter==POLL_PERIOD-1 and enable=1, clear the counter and go to RSTP.
  - RSTP: spi_rstn=0 for exactly RSTN_CYCLES cycles, then go to START.
  - START: spi_start=1 for exactly one cycle, spi_rstn=1; load the timeout counter with 0; go to WAIT.
  - WAIT: on spi_done=1, register spi_data into an internal capture register and go to CHECK. Otherwise increment the timeout counter. When it reaches TIMEOUT-1, set timeout_flag, increment err_cnt and go to IDLE.
  - CHECK: one cycle; evaluate the captured word.
    - If sync and checksum both match: write regfile[addr]=data, drive param_we=1 for this cycle with param_addr/param_data updated, then go to IDLE.
    - If either mismatches: increment err_cnt, leave the register file untouched, go to IDLE.
- spi_rstn and spi_start are registered outputs; spi_start and spi_rstn=0 are never asserted in the same cycle.
- spi_done outside WAIT is ignored.
- enable dropping mid-transaction does not abort; the current transaction completes and the next one does not start.
- err_cnt saturates at 8'hFF and does not wrap; incrementing on timeout and mismatch never coincides because they occur in different states.
- Read port: rd_data <= regfile[rd_addr] every clk.
  - If a write to the same address occurs in that cycle, rd_data returns the old value; the new value is returned the next cycle.
- Minimum transaction spacing is POLL_PERIOD + RSTN_CYCLES + 1 + WAIT duration + 1 cycles.

Optional Feature:
- Macro: SHADOW_BANK_EN.
- When defined:
  - Valid words write a shadow register file, not the live one.
  - A valid word with address 4'hF copies all 15 shadow entries 0..14 into the live file in one cycle, so parameter updates stay atomic. Entry 15 is never stored.
  - param_we pulses only on commit, with param_addr=4'hF and param_data equal to the word's data field.
  - rd_data reads the live file.
  - Reset clears both banks.
- When undefined: no shadow storage; every valid word, including address 4'hF, writes the live file immediately as described above.

Test Plan:
- Rst release, enable=1, POLL_PERIOD=16 -> spi_rstn low 2 cycles starting 16 cycles after enable; spi_start one-cycle pulse immediately after; no overlap between the two.
- Model returns spi_done with 0xA3_12_34_85 (checksum 0xA3^0x12^0x34=0x85) -> param_we pulse one cycle after done, param_addr=3, param_data=0x1234; rd_addr=3 next cycle gives rd_data=0x1234.
- Word 0xA3_12_34_00 (bad checksum) or 0x53_12_34_75 (bad sync) -> no param_we, regfile unchanged, err_cnt increments by 1 per word.
- Model never asserts spi_done, TIMEOUT=8 -> after 8 WAIT cycles timeout_flag=1, err_cnt+1, FSM returns to IDLE and polls again; 300 consecutive errors -> err_cnt=255.
- Assert rst mid-WAIT -> all outputs reset immediately without waiting for a clock edge; spi_done in the following cycle causes no write.
- SHADOW_BANK_EN: write addr 1=0x1111 and addr 2=0x2222 -> rd_data for both is still 0; word to addr F -> single param_we, then both read back their new values.

Source files
------------

// File: rtl/synth_param_decoder.sv
// Sequences SPI capture transactions, validates each returned word and updates the synth parameter file.
// Optional SHADOW_BANK_EN: valid words stage into a shadow bank and a write to address 4'hF commits it atomically.
module synth_param_decoder #(
    parameter int         POLL_PERIOD = 4096,
    parameter int         RSTN_CYCLES = 2,
    parameter int         TIMEOUT     = 1024,
    parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        spi_rstn,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic [31:0] spi_data,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        param_we,
    output logic [3:0]  param_addr,
    output logic [15:0] param_data,
    output logic [7:0]  err_cnt,
    output logic        timeout_flag
);

    localparam int POLL_W = $clog2(POLL_PERIOD + 1);
    localparam int RST_W  = $clog2(RSTN_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RSTN_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTP,
        S_START,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t             r_state;
    logic [POLL_W-1:0]  r_poll_cnt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [31:0]        r_word;
    logic               r_spi_rstn;
    logic               r_spi_start;
    logic               r_param_we;
    logic [3:0]         r_param_addr;
    logic [15:0]        r_param_data;
    logic [7:0]         r_err_cnt;
    logic               r_timeout_flag;
    logic [15:0]        r_rd_data;

    logic [15:0][15:0]  w_live;
    logic               w_in_ok;
    logic               w_in_pulse;
    logic [3:0]         w_in_addr;
    logic [15:0]        w_in_data;
    logic               w_cap_ok;
    logic               w_cap_wr;
    logic [3:0]         w_cap_addr;
    logic [15:0]        w_cap_data;

    function automatic logic word_ok(input logic [31:0] w);
        return (w[31:28] == SYNC_NIBBLE) && (w[7:0] == (w[31:24] ^ w[23:16] ^ w[15:8]));
    endfunction

    assign w_in_ok    = word_ok(spi_data);
    assign w_in_addr  = spi_data[27:24];
    assign w_in_data  = spi_data[23:8];
    assign w_cap_ok   = word_ok(r_word);
    assign w_cap_addr = r_word[27:24];
    assign w_cap_data = r_word[23:8];
    assign w_cap_wr   = (r_state == S_CHECK) && w_cap_ok;

    // Validity is pre-evaluated on the incoming word so param_we lands in the CHECK cycle itself.
`ifdef SHADOW_BANK_EN
    logic w_commit;
    assign w_commit   = w_cap_wr && (w_cap_addr == 4'hF);
    assign w_in_pulse = w_in_ok && (w_in_addr == 4'hF);
`else
    assign w_in_pulse = w_in_ok;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_poll_cnt     <= '0;
            r_rst_cnt      <= '0;
            r_to_cnt       <= '0;
            r_word         <= '0;
            r_spi_rstn     <= 1'b1;
            r_spi_start    <= 1'b0;
            r_param_we     <= 1'b0;
            r_param_addr   <= '0;
            r_param_data   <= '0;
            r_err_cnt      <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_param_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (r_poll_cnt == POLL_LAST) begin
                            r_poll_cnt <= '0;
                            r_rst_cnt  <= '0;
                            r_spi_rstn <= 1'b0;
                            r_state    <= S_RSTP;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + POLL_W'(1);
                        end
                    end
                end
                S_RSTP: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_spi_rstn  <= 1'b1;
                        r_spi_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    end
                end
                S_START: begin
                    r_spi_start <= 1'b0;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        r_word     <= spi_data;
                        r_param_we <= w_in_pulse;
                        if (w_in_pulse) begin
                            r_param_addr <= w_in_addr;
                            r_param_data <= w_in_data;
                        end
                        r_state <= S_CHECK;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout_flag <= 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!w_cap_ok && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Entries are discrete flops: the file must clear on reset and the shadow commit loads all entries at once.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_entry
`ifdef SHADOW_BANK_EN
            if (gi < 15) begin : g_bank
                logic [15:0] r_shadow;
                logic [15:0] r_live;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_shadow <= '0;
                        r_live   <= '0;
                    end else begin
                        if (w_cap_wr && (w_cap_addr == 4'(gi))) begin
                            r_shadow <= w_cap_data;
                        end
                        if (w_commit) begin
                            r_live <= r_shadow;
                        end
                    end
                end
                assign w_live[gi] = r_live;
            end else begin : g_commit_slot
                assign w_live[gi] = 16'd0;
            end
`else
            logic [15:0] r_live;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_live <= '0;
                end else if (w_cap_wr && (w_cap_addr == 4'(gi))) begin
                    r_live <= w_cap_data;
                end
            end
            assign w_live[gi] = r_live;
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_live[rd_addr];
        end
    end

    assign spi_rstn     = r_spi_rstn;
    assign spi_start    = r_spi_start;
    assign param_we     = r_param_we;
    assign param_addr   = r_param_addr;
    assign param_data   = r_param_data;
    assign err_cnt      = r_err_cnt;
    assign timeout_flag = r_timeout_flag;
    assign rd_data      = r_rd_data;

endmodule
